// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue controller in front of the ALU result mux.
// Accepts one op per cycle and decodes its class into the mux one-hot en.
// It sequences the multi-cycle shifter and returns a response pulse that lines
// up with the mux's registered output.
// Optional build macro ALU_ISSUE_PERF_EN adds the saturating perf_issued and
// perf_stall counters.
module alu_issue_ctrl #(
  parameter int unsigned SHIFT_LAT = 3,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_class,
  input  logic [TAG_W-1:0] req_tag,
  output logic [2:0]       en,
  output logic             shift_start,
  output logic             resp_valid,
  output logic [TAG_W-1:0] resp_tag,
`ifdef ALU_ISSUE_PERF_EN
  output logic             resp_err,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`else
  output logic             resp_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam logic [1:0] CLS_ADD   = 2'b00;
  localparam logic [1:0] CLS_BOOL  = 2'b01;
  localparam logic [1:0] CLS_SHIFT = 2'b10;
  localparam logic [1:0] CLS_ILL   = 2'b11;

  state_t           state;
  logic [3:0]       cnt;
  logic [1:0]       cur_class;
  logic [TAG_W-1:0] cur_tag;
  logic             accept;
  logic             done;

  // Ready depends only on state/count so upstream never sees a valid->ready loop
  always_comb begin
    req_ready = (state != SHIFT) || (cnt == 4'd0);
    accept    = req_valid && req_ready;
    done      = (state == EXEC) || ((state == SHIFT) && (cnt == 4'd0));
  end

  // Main FSM; en/shift_start are computed one cycle early so they leave a flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_class   <= '0;
      cur_tag     <= '0;
      en          <= '0;
      shift_start <= 1'b0;
    end else begin
      en          <= '0;
      shift_start <= 1'b0;
      if ((state == SHIFT) && (cnt != 4'd0)) begin
        // Shift still running: count down, raise en[2] for the final cycle
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1)
          en <= 3'b100;
      end else if (accept) begin
        cur_class <= req_class;
        cur_tag   <= req_tag;
        if (req_class == CLS_SHIFT) begin
          state       <= SHIFT;
          cnt         <= 4'(SHIFT_LAT - 1);
          shift_start <= 1'b1;
          if (SHIFT_LAT == 1)
            en <= 3'b100;
        end else begin
          state <= EXEC;
          cnt   <= '0;
          case (req_class)
            CLS_ADD:  en <= 3'b001;
            CLS_BOOL: en <= 3'b010;
            default:  en <= 3'b000;
          endcase
        end
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

  // Response registered from the completing cycle, aligned with mux output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_tag   <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= done;
      resp_tag   <= done ? cur_tag : '0;
      resp_err   <= (state == EXEC) && (cur_class == CLS_ILL);
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // Saturating counters of accepted ops and stalled request cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept && (perf_issued != '1))
        perf_issued <= perf_issued + 32'd1;
      if (req_valid && !req_ready && (perf_stall != '1))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl: one instance with SHIFT_LAT=3 and one
// with SHIFT_LAT=1. The perf counter test is built only with ALU_ISSUE_PERF_EN.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, shift_start, resp_valid, resp_err;
  logic [1:0] req_class;
  logic [3:0] req_tag, resp_tag;
  logic [2:0] en;
  logic       v1, r1, ss1, rv1, re1;
  logic [1:0] c1;
  logic [3:0] t1, rt1;
  logic [2:0] en1;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall, pi1, ps1;
`endif

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SHIFT_LAT(3), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_tag(req_tag), .en(en), .shift_start(shift_start),
    .resp_valid(resp_valid), .resp_tag(resp_tag),
`ifdef ALU_ISSUE_PERF_EN
    .resp_err(resp_err), .perf_issued(perf_issued), .perf_stall(perf_stall)
`else
    .resp_err(resp_err)
`endif
  );

  alu_issue_ctrl #(.SHIFT_LAT(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1),
    .req_class(c1), .req_tag(t1), .en(en1), .shift_start(ss1),
    .resp_valid(rv1), .resp_tag(rt1),
`ifdef ALU_ISSUE_PERF_EN
    .resp_err(re1), .perf_issued(pi1), .perf_stall(ps1)
`else
    .resp_err(re1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [3:0] t);
    req_valid = v; req_class = c; req_tag = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'b00, 4'h0);
    v1 = 1'b0; c1 = 2'b00; t1 = 4'h0;
    step(); step();
    tests_run++;
    if ({en, shift_start, resp_valid, resp_err, resp_tag} !== 10'b0) begin
      failures++; $display("FAIL reset_outputs got %b exp 0", {en, shift_start, resp_valid, resp_err, resp_tag});
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_reset_mid_shift();
    bit seen;
    seen = 1'b0;
    drive(1'b1, 2'b10, 4'h9);
    step();                      // cycle 1: cnt=2
    drive(1'b0, 2'b00, 4'h0);
    step();                      // cycle 2: cnt=1
    rst = 1'b1;
    #1;
    tests_run++;
    if (en !== 3'b000 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_shift en=%b rv=%b exp 000/0", en, resp_valid);
    end
    step();
    rst = 1'b0;
    step();
    tests_run++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    for (int i = 0; i < 5; i++) begin
      if (resp_valid === 1'b1 || en !== 3'b000) seen = 1'b1;
      step();
    end
    tests_run++;
    if (seen) begin failures++; $display("FAIL rst_discard got response/en exp none"); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'b00, 4'h1);
    step();                      // cycle 1
    tests_run++;
    if (en !== 3'b001 || resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_c1 en=%b rv=%b exp 001/0", en, resp_valid); end
    drive(1'b1, 2'b01, 4'h2);
    step();                      // cycle 2
    tests_run++;
    if (en !== 3'b010 || resp_valid !== 1'b1 || resp_tag !== 4'h1 || resp_err !== 1'b0) begin
      failures++; $display("FAIL b2b_c2 en=%b rv=%b tag=%h err=%b exp 010/1/1/0", en, resp_valid, resp_tag, resp_err);
    end
    drive(1'b1, 2'b00, 4'h3);
    step();                      // cycle 3
    tests_run++;
    if (en !== 3'b001 || resp_valid !== 1'b1 || resp_tag !== 4'h2 || resp_err !== 1'b0) begin
      failures++; $display("FAIL b2b_c3 en=%b rv=%b tag=%h err=%b exp 001/1/2/0", en, resp_valid, resp_tag, resp_err);
    end
    drive(1'b0, 2'b00, 4'h0);
    step();                      // cycle 4
    tests_run++;
    if (en !== 3'b000 || resp_valid !== 1'b1 || resp_tag !== 4'h3 || resp_err !== 1'b0) begin
      failures++; $display("FAIL b2b_c4 en=%b rv=%b tag=%h err=%b exp 000/1/3/0", en, resp_valid, resp_tag, resp_err);
    end
    step();                      // cycle 5
    tests_run++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_c5 rv=%b exp 0", resp_valid); end
  endtask

  task automatic test_shift();
    logic [2:0] exp_en [1:4];
    logic       exp_ss [1:4];
    logic       exp_rdy[1:4];
    logic       exp_rv [1:4];
    exp_en  = '{3'b000, 3'b000, 3'b100, 3'b000};
    exp_ss  = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_rv  = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b1, 2'b10, 4'h5);
    for (int c = 1; c <= 4; c++) begin
      step();
      drive(1'b0, 2'b00, 4'h0);
      tests_run++;
      if (en !== exp_en[c] || shift_start !== exp_ss[c] || req_ready !== exp_rdy[c] || resp_valid !== exp_rv[c]) begin
        failures++;
        $display("FAIL shift_c%0d en=%b ss=%b rdy=%b rv=%b exp %b/%b/%b/%b", c, en, shift_start, req_ready,
                 resp_valid, exp_en[c], exp_ss[c], exp_rdy[c], exp_rv[c]);
      end
    end
    tests_run++;
    if (resp_tag !== 4'h5 || resp_err !== 1'b0) begin failures++; $display("FAIL shift_resp tag=%h err=%b exp 5/0", resp_tag, resp_err); end
    step();
  endtask

  task automatic test_illegal();
    drive(1'b1, 2'b11, 4'h7);
    step();                      // cycle 1
    drive(1'b0, 2'b00, 4'h0);
    tests_run++;
    if (en !== 3'b000 || shift_start !== 1'b0 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL ill_c1 en=%b ss=%b rv=%b exp 000/0/0", en, shift_start, resp_valid);
    end
    step();                      // cycle 2
    tests_run++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_tag !== 4'h7 || en !== 3'b000) begin
      failures++; $display("FAIL ill_c2 rv=%b err=%b tag=%h en=%b exp 1/1/7/000", resp_valid, resp_err, resp_tag, en);
    end
    step();
    tests_run++;
    if (resp_err !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL ill_c3 rv=%b err=%b exp 0/0", resp_valid, resp_err); end
  endtask

  task automatic test_shift_then_add();
    drive(1'b1, 2'b10, 4'h5);
    step();                      // cycle 1: shift accepted; add presented, held
    drive(1'b1, 2'b00, 4'h6);
    step();                      // cycle 2
    tests_run++;
    if (req_ready !== 1'b0 || en !== 3'b000) begin failures++; $display("FAIL sa_c2 rdy=%b en=%b exp 0/000", req_ready, en); end
    step();                      // cycle 3: final shift cycle, add accepted here
    tests_run++;
    if (req_ready !== 1'b1 || en !== 3'b100) begin failures++; $display("FAIL sa_c3 rdy=%b en=%b exp 1/100", req_ready, en); end
    step();                      // cycle 4
    drive(1'b0, 2'b00, 4'h0);
    tests_run++;
    if (en !== 3'b001 || resp_valid !== 1'b1 || resp_tag !== 4'h5) begin
      failures++; $display("FAIL sa_c4 en=%b rv=%b tag=%h exp 001/1/5", en, resp_valid, resp_tag);
    end
    step();                      // cycle 5
    tests_run++;
    if (en !== 3'b000 || resp_valid !== 1'b1 || resp_tag !== 4'h6) begin
      failures++; $display("FAIL sa_c5 en=%b rv=%b tag=%h exp 000/1/6", en, resp_valid, resp_tag);
    end
    step();
  endtask

  task automatic test_lat1_rate();
    v1 = 1'b1; c1 = 2'b10; t1 = 4'h5;
    step();                      // cycle 1
    tests_run++;
    if (ss1 !== 1'b1 || en1 !== 3'b100 || r1 !== 1'b1) begin
      failures++; $display("FAIL lat1_c1 ss=%b en=%b rdy=%b exp 1/100/1", ss1, en1, r1);
    end
    c1 = 2'b00; t1 = 4'h6;
    step();                      // cycle 2
    v1 = 1'b0;
    tests_run++;
    if (en1 !== 3'b001 || ss1 !== 1'b0 || rv1 !== 1'b1 || rt1 !== 4'h5) begin
      failures++; $display("FAIL lat1_c2 en=%b ss=%b rv=%b tag=%h exp 001/0/1/5", en1, ss1, rv1, rt1);
    end
    step();                      // cycle 3
    tests_run++;
    if (en1 !== 3'b000 || rv1 !== 1'b1 || rt1 !== 4'h6 || re1 !== 1'b0) begin
      failures++; $display("FAIL lat1_c3 en=%b rv=%b tag=%h err=%b exp 000/1/6/0", en1, rv1, rt1, re1);
    end
    step();
  endtask

`ifdef ALU_ISSUE_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if (perf_issued !== 32'd0 || perf_stall !== 32'd0) begin
      failures++; $display("FAIL perf_reset issued=%0d stall=%0d exp 0/0", perf_issued, perf_stall);
    end
    drive(1'b1, 2'b10, 4'h5);
    step();
    drive(1'b1, 2'b00, 4'h6);
    step(); step(); step();
    drive(1'b0, 2'b00, 4'h0);
    tests_run++;
    if (perf_issued !== 32'd2 || perf_stall !== 32'd2) begin
      failures++; $display("FAIL perf_counts issued=%0d stall=%0d exp 2/2", perf_issued, perf_stall);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_shift();
    test_illegal();
    test_shift_then_add();
    test_lat1_rate();
    test_reset_mid_shift();
`ifdef ALU_ISSUE_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
